// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared H/V timing state encodings and 1080p60 default constants
package video_timing_pkg;

    typedef enum logic [1:0] {
        AX_ACT   = 2'd0,
        AX_FRONT = 2'd1,
        AX_SYNC  = 2'd2,
        AX_BACK  = 2'd3
    } axis_state_t;

    // Horizontal and vertical axes walk the same four-phase sequence.
    typedef axis_state_t h_state_t;
    typedef axis_state_t v_state_t;

    localparam int DEF_BUS_WIDTH = 12;
    localparam int DEF_H_ACTIVE  = 1920;
    localparam int DEF_H_FP      = 88;
    localparam int DEF_H_SYNC    = 44;
    localparam int DEF_H_BP      = 148;
    localparam int DEF_V_ACTIVE  = 1080;
    localparam int DEF_V_FP      = 4;
    localparam int DEF_V_SYNC    = 5;
    localparam int DEF_V_BP      = 36;

endpackage

// File: rtl/timing_axis.sv
// rtl/timing_axis.sv - one timing axis: position counter plus active/front/sync/back FSM
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int W      = DEF_BUS_WIDTH,
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         advance,
    output logic [W-1:0] count,
    output axis_state_t  state_next,
    output logic         wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    // Last position of each phase; the FSM moves on when the count leaves it.
    localparam logic [W-1:0] END_ACT  = W'(ACTIVE - 1);
    localparam logic [W-1:0] END_FP   = W'(ACTIVE + FP - 1);
    localparam logic [W-1:0] END_SYNC = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] ONE      = W'(1);

    axis_state_t  state;
    logic [W-1:0] count_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= LAST;
            state <= AX_BACK;
        end else begin
            count <= count_next;
            state <= state_next;
        end
    end

    always_comb begin
        count_next = count;
        state_next = state;
        wrap       = 1'b0;
        if (advance) begin
            if (count == LAST) begin
                count_next = '0;
                state_next = AX_ACT;
                wrap       = 1'b1;
            end else begin
                count_next = count + ONE;
                if (count == END_ACT)
                    state_next = AX_FRONT;
                else if (count == END_FP)
                    state_next = AX_SYNC;
                else if (count == END_SYNC)
                    state_next = AX_BACK;
            end
        end
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - raster timing generator; VTC_FRAME_COUNTER_EN adds a 16-bit frameCount output
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int busWidth = DEF_BUS_WIDTH,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic [busWidth-1:0] hCount,
    output logic [busWidth-1:0] vCount,
    output logic                hSync,
    output logic                vSync,
    output logic                dataEnable,
    output logic                lineStart,
    output logic                frameStart
`ifdef VTC_FRAME_COUNTER_EN
    ,
    output logic [15:0]         frameCount
`endif
);

    h_state_t h_state_next;
    v_state_t v_state_next;
    logic     h_wrap;
    logic     v_wrap;

    timing_axis #(
        .W      (busWidth),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clock      (clock),
        .reset      (reset),
        .advance    (enable),
        .count      (hCount),
        .state_next (h_state_next),
        .wrap       (h_wrap)
    );

    timing_axis #(
        .W      (busWidth),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clock      (clock),
        .reset      (reset),
        .advance    (h_wrap),
        .count      (vCount),
        .state_next (v_state_next),
        .wrap       (v_wrap)
    );

    // Flags are registered from the axes' next state so they land in the
    // same cycle as the counter values they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            dataEnable <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            hSync      <= ~H_POL;
            vSync      <= ~V_POL;
        end else if (enable) begin
            dataEnable <= (h_state_next == AX_ACT) && (v_state_next == AX_ACT);
            lineStart  <= h_wrap;
            frameStart <= v_wrap;
            hSync      <= (h_state_next == AX_SYNC) ? H_POL : ~H_POL;
            vSync      <= (v_state_next == AX_SYNC) ? V_POL : ~V_POL;
        end
    end

`ifdef VTC_FRAME_COUNTER_EN
    always_ff @(posedge clock) begin
        if (reset)
            frameCount <= 16'd0;
        else if (v_wrap)
            frameCount <= frameCount + 16'd1;
    end
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - directed bench for video_timing_ctrl (small, inverted-polarity and 1080p instances)
module tb_video_timing_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int mh = 0;
    int mv = 0;

    logic [11:0] s_h, s_v, p_h, p_v, b_h, b_v;
    logic s_hs, s_vs, s_de, s_ls, s_fs;
    logic p_hs, p_vs, p_de, p_ls, p_fs;
    logic b_hs, b_vs, b_de, b_ls, b_fs;
`ifdef VTC_FRAME_COUNTER_EN
    logic [15:0] s_fc, p_fc, b_fc;
`endif

    video_timing_ctrl #(
        .busWidth(12), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
    ) u_small (
        .clock(clock), .reset(reset), .enable(enable),
        .hCount(s_h), .vCount(s_v), .hSync(s_hs), .vSync(s_vs),
        .dataEnable(s_de), .lineStart(s_ls), .frameStart(s_fs)
`ifdef VTC_FRAME_COUNTER_EN
        , .frameCount(s_fc)
`endif
    );

    video_timing_ctrl #(
        .busWidth(12), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0)
    ) u_pol0 (
        .clock(clock), .reset(reset), .enable(enable),
        .hCount(p_h), .vCount(p_v), .hSync(p_hs), .vSync(p_vs),
        .dataEnable(p_de), .lineStart(p_ls), .frameStart(p_fs)
`ifdef VTC_FRAME_COUNTER_EN
        , .frameCount(p_fc)
`endif
    );

    video_timing_ctrl u_big (
        .clock(clock), .reset(reset), .enable(enable),
        .hCount(b_h), .vCount(b_v), .hSync(b_hs), .vSync(b_vs),
        .dataEnable(b_de), .lineStart(b_ls), .frameStart(b_fs)
`ifdef VTC_FRAME_COUNTER_EN
        , .frameCount(b_fc)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_step();
        if (mh == 13) begin
            mh = 0;
            mv = (mv == 6) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        checks++;
        if ({s_h, s_v, s_de, s_ls, s_fs, s_hs, s_vs} !== {12'd13, 12'd6, 5'b00000})
            begin errors++; $display("FAIL reset_small got h=%0d v=%0d de=%b ls=%b fs=%b hs=%b vs=%b want 13 6 0 0 0 0 0", s_h, s_v, s_de, s_ls, s_fs, s_hs, s_vs); end
        checks++;
        if ({p_hs, p_vs, p_de} !== 3'b110)
            begin errors++; $display("FAIL reset_pol0 got hs=%b vs=%b de=%b want 1 1 0", p_hs, p_vs, p_de); end
        checks++;
        if ({b_h, b_v, b_de, b_ls, b_fs} !== {12'd2199, 12'd1124, 3'b000})
            begin errors++; $display("FAIL reset_big got h=%0d v=%0d de=%b ls=%b fs=%b want 2199 1124 0 0 0", b_h, b_v, b_de, b_ls, b_fs); end
    endtask

    task automatic test_first_edge();
        reset = 1'b0;
        enable = 1'b1;
        tick();
        mh = 0;
        mv = 0;
        checks++;
        if ({s_h, s_v, s_de, s_ls, s_fs, s_hs, s_vs} !== {12'd0, 12'd0, 5'b11100})
            begin errors++; $display("FAIL first_edge_small got h=%0d v=%0d de=%b ls=%b fs=%b hs=%b vs=%b want 0 0 1 1 1 0 0", s_h, s_v, s_de, s_ls, s_fs, s_hs, s_vs); end
        checks++;
        if ({b_h, b_v, b_de, b_ls, b_fs} !== {12'd0, 12'd0, 3'b111})
            begin errors++; $display("FAIL first_edge_big got h=%0d v=%0d de=%b ls=%b fs=%b want 0 0 1 1 1", b_h, b_v, b_de, b_ls, b_fs); end
    endtask

    task automatic test_small_frames();
        logic e_de, e_hs, e_vs, e_ls, e_fs;
        for (int i = 0; i < 2 * 98; i++) begin
            tick();
            model_step();
            e_de = (mh < 8) && (mv < 4);
            e_hs = (mh >= 10) && (mh <= 11);
            e_vs = (mv == 5);
            e_ls = (mh == 0);
            e_fs = (mh == 0) && (mv == 0);
            checks++;
            if ({s_h, s_v, s_de, s_ls, s_fs, s_hs, s_vs} !== {12'(mh), 12'(mv), e_de, e_ls, e_fs, e_hs, e_vs})
                begin errors++; $display("FAIL frame_small got h=%0d v=%0d de=%b ls=%b fs=%b hs=%b vs=%b want %0d %0d %b %b %b %b %b",
                    s_h, s_v, s_de, s_ls, s_fs, s_hs, s_vs, mh, mv, e_de, e_ls, e_fs, e_hs, e_vs); end
            checks++;
            if ({p_hs, p_vs, p_de} !== {~e_hs, ~e_vs, e_de})
                begin errors++; $display("FAIL frame_pol0 at h=%0d v=%0d got hs=%b vs=%b de=%b want %b %b %b",
                    mh, mv, p_hs, p_vs, p_de, ~e_hs, ~e_vs, e_de); end
        end
    endtask

    task automatic test_enable_hold();
        for (int i = 0; i < 200 && !(mh == 13 && mv == 6); i++) begin
            tick();
            model_step();
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({s_h, s_v, s_de, s_ls, s_fs, s_hs, s_vs} !== {12'd13, 12'd6, 5'b00000})
                begin errors++; $display("FAIL hold_frozen cycle %0d got h=%0d v=%0d de=%b ls=%b fs=%b hs=%b vs=%b want 13 6 0 0 0 0 0", i, s_h, s_v, s_de, s_ls, s_fs, s_hs, s_vs); end
        end
        enable = 1'b1;
        tick();
        mh = 0;
        mv = 0;
        checks++;
        if ({s_h, s_v, s_de, s_ls, s_fs} !== {12'd0, 12'd0, 3'b111})
            begin errors++; $display("FAIL hold_resume got h=%0d v=%0d de=%b ls=%b fs=%b want 0 0 1 1 1", s_h, s_v, s_de, s_ls, s_fs); end
        enable = 1'b0;
        tick();
        tick();
        checks++;
        if ({s_h, s_ls, s_fs} !== {12'd0, 2'b11})
            begin errors++; $display("FAIL hold_pulse got h=%0d ls=%b fs=%b want 0 1 1", s_h, s_ls, s_fs); end
        enable = 1'b1;
        tick();
        mh = 1;
        checks++;
        if ({s_h, s_v, s_ls, s_fs} !== {12'd1, 12'd0, 2'b00})
            begin errors++; $display("FAIL hold_single_pulse got h=%0d v=%0d ls=%b fs=%b want 1 0 0 0", s_h, s_v, s_ls, s_fs); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 20 && mh != 10; i++) begin
            tick();
            model_step();
        end
        checks++;
        if ({s_h, s_hs, p_hs} !== {12'd10, 2'b10})
            begin errors++; $display("FAIL mid_pre got h=%0d hs=%b pol0_hs=%b want 10 1 0", s_h, s_hs, p_hs); end
        reset = 1'b1;
        tick();
        checks++;
        if ({s_h, s_v, s_de, s_hs, s_ls, s_fs, p_hs} !== {12'd13, 12'd6, 5'b00001})
            begin errors++; $display("FAIL mid_abort got h=%0d v=%0d de=%b hs=%b ls=%b fs=%b pol0_hs=%b want 13 6 0 0 0 0 1", s_h, s_v, s_de, s_hs, s_ls, s_fs, p_hs); end
        reset = 1'b0;
        tick();
        mh = 0;
        mv = 0;
        checks++;
        if ({s_h, s_v, s_de, s_ls, s_fs} !== {12'd0, 12'd0, 3'b111})
            begin errors++; $display("FAIL mid_restart got h=%0d v=%0d de=%b ls=%b fs=%b want 0 0 1 1 1", s_h, s_v, s_de, s_ls, s_fs); end
    endtask

    task automatic test_frame_counter();
`ifdef VTC_FRAME_COUNTER_EN
        int n;
        reset = 1'b1;
        tick();
        checks++;
        if (s_fc !== 16'd0)
            begin errors++; $display("FAIL fc_reset got %0d want 0", s_fc); end
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 2 * 98 + 1; i++) begin
            tick();
            if (s_fs === 1'b1) begin
                n++;
                checks++;
                if (s_fc !== 16'(n))
                    begin errors++; $display("FAIL fc_value got %0d want %0d", s_fc, n); end
            end
        end
        checks++;
        if (n != 3)
            begin errors++; $display("FAIL fc_pulses got %0d want 3", n); end
`endif
    endtask

    task automatic test_big_line();
        int ls_at[3];
        int n_ls, n_de, n_hs, n_fs, first_hs;
        reset = 1'b1;
        enable = 1'b1;
        tick();
        reset = 1'b0;
        n_ls = 0; n_de = 0; n_hs = 0; n_fs = 0; first_hs = -1;
        for (int c = 0; c < 4500; c++) begin
            tick();
            if (b_ls === 1'b1 && n_ls < 3) begin
                ls_at[n_ls] = c;
                n_ls++;
            end
            if (b_fs === 1'b1) n_fs++;
            if (c < 2200 && b_de === 1'b1) n_de++;
            if (c < 2200 && b_hs === 1'b1) begin
                n_hs++;
                if (first_hs < 0) first_hs = c;
            end
        end
        checks++;
        if (n_ls != 3 || ls_at[0] != 0 || ls_at[1] != 2200 || ls_at[2] != 4400)
            begin errors++; $display("FAIL big_line_period got n=%0d at %0d %0d %0d want 3 at 0 2200 4400", n_ls, ls_at[0], ls_at[1], ls_at[2]); end
        checks++;
        if (n_de != 1920)
            begin errors++; $display("FAIL big_de_per_line got %0d want 1920", n_de); end
        checks++;
        if (n_hs != 44 || first_hs != 2008)
            begin errors++; $display("FAIL big_hsync got len=%0d start=%0d want 44 2008", n_hs, first_hs); end
        checks++;
        if (n_fs != 1)
            begin errors++; $display("FAIL big_frame_pulses got %0d want 1", n_fs); end
        checks++;
        if ({b_h, b_v, b_vs} !== {12'd99, 12'd2, 1'b0})
            begin errors++; $display("FAIL big_position got h=%0d v=%0d vs=%b want 99 2 0", b_h, b_v, b_vs); end
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_small_frames();
        test_enable_hold();
        test_reset_mid();
        test_frame_counter();
        test_big_line();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 Parameters SHALL be busWidth (12, width of both counters), H_ACTIVE (1920), H_FP (88), H_SYNC (44), H_BP (148), V_ACTIVE (1080), V_FP (4), V_SYNC (5), V_BP (36), H_POL (1, hSync asserted level), V_POL (1, vSync asserted level).
REQ-002 Derived constants SHALL be H_TOTAL = sum of H_* periods (2200) and V_TOTAL = sum of V_* periods (1125); each SHALL be at most 2^busWidth.
REQ-003 clock  input  1  single rising-edge clock; all logic is in this domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  pixel-advance qualifier; when low, all state holds.
REQ-006 hCount  output  busWidth  current pixel column, 0..H_TOTAL-1.
REQ-007 vCount  output  busWidth  current line, 0..V_TOTAL-1.
REQ-008 hSync  output  1  horizontal sync, at level H_POL when asserted.
REQ-009 vSync  output  1  vertical sync, at level V_POL when asserted.
REQ-010 dataEnable  output  1  high for active-video pixels.
REQ-011 lineStart  output  1  high for the single cycle where hCount = 0.
REQ-012 frameStart  output  1  high for the single cycle where hCount = 0 and vCount = 0.

Function
REQ-013 Horizontal FSM SHALL have states H_ACT, H_FRONT, H_SYNC, H_BACK, entered at hCount = 0, H_ACTIVE, H_ACTIVE+H_FP and H_ACTIVE+H_FP+H_SYNC respectively; it returns to H_ACT when hCount wraps.
REQ-014 Vertical FSM SHALL have states V_ACT, V_FRONT, V_SYNC, V_BACK, with boundaries at the corresponding V_* sums; it advances only on a horizontal wrap.
REQ-015 On each clock with enable = 1, hCount SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0.
REQ-016 vCount SHALL increment only on the cycle where hCount wraps; at V_TOTAL-1 it SHALL wrap to 0 in the same cycle as hCount.
REQ-017 All outputs SHALL be registered and mutually aligned: each flag reflects the hCount/vCount value presented in the same cycle, with zero relative latency.
REQ-018 dataEnable SHALL be 1 iff the H state is H_ACT and the V state is V_ACT.
REQ-019 hSync SHALL equal H_POL iff the H state is H_SYNC, and ~H_POL otherwise; vSync SHALL equal V_POL iff the V state is V_SYNC, and ~V_POL otherwise.
REQ-020 The vSync edges SHALL coincide with the hCount = 0 cycle of the first and last-plus-one V_SYNC lines.
REQ-021 With enable = 0, all outputs SHALL hold their values, including lineStart and frameStart; no pulse SHALL be repeated or lost.
REQ-022 reset SHALL take priority over enable when both are high.

Reset
REQ-023 While reset = 1, the block SHALL hold hCount = H_TOTAL-1, vCount = V_TOTAL-1, H state = H_BACK, V state = V_BACK, dataEnable = 0, lineStart = 0, frameStart = 0, hSync = ~H_POL and vSync = ~V_POL.
REQ-024 The first enabled edge after reset SHALL present hCount = 0, vCount = 0, dataEnable = 1, lineStart = 1 and frameStart = 1.
REQ-025 A reset asserted mid-frame SHALL abort the frame on the next edge, with no partial sync pulse stretched past that edge.

Configuration
REQ-026 Macro VTC_FRAME_COUNTER_EN: when defined, the block SHALL add output frameCount (16 bits, reset 0), which increments on every frameStart cycle and wraps at 0xFFFF to 0.
REQ-027 When VTC_FRAME_COUNTER_EN is undefined, the frameCount port and its logic SHALL be absent.

Structure
REQ-028 A shared package video_timing_pkg SHALL hold the H/V state enumerations and the 1080p60 default constants, for reuse by the line-buffer and overlay blocks.
REQ-029 One sub-module, timing_axis, SHALL implement a single counter+FSM axis, with an advance input and a wrap output; it is instantiated once for horizontal and once for vertical, the vertical advance being driven by the horizontal wrap.

Verification
REQ-030 Small parameters (H 8/2/2/2, V 4/1/1/1, POL 1), reset then enable held high -> hCount cycles 0..13, dataEnable high on hCount 0..7 of lines 0..3, hSync high at hCount 10..11, vSync high on line 5.
REQ-031 Default 1080p parameters, run 2 frames -> exactly 2200 clocks between lineStart pulses, 2475000 clocks between frameStart pulses, 1920x1080 dataEnable cycles per frame.
REQ-032 Toggle enable low for 3 cycles at hCount = 13, vCount = 6 (small parameters) -> outputs frozen for 3 cycles, then wrap to (0,0) with a single frameStart.
REQ-033 Assert reset at hCount = 10 (hSync high) -> next edge gives hSync = 0, hCount = 13, dataEnable = 0; after release, frameStart on the first enabled edge.
REQ-034 H_POL = 0, V_POL = 0 -> hSync and vSync idle high and pulse low over the identical windows of REQ-030.
REQ-035 VTC_FRAME_COUNTER_EN defined, run 3 frames -> frameCount reads 1, 2, 3 on successive frameStart cycles, and 0 during reset.
